// File: rtl/led_scan_sequencer.sv
// Drives the 3-bit index and enable code of the registered 3-to-8 LED decoder.
// The index auto-scans up, down or ping-pong at a programmable rate, or is loaded directly.
module led_scan_sequencer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] period,
    input  logic             blank,
    input  logic             load_valid,
    input  logic [2:0]       load_idx,
    output logic             load_ready,
    output logic [2:0]       switch,
    output logic [2:0]       enable,
    output logic             tick,
    output logic             wrap
);

    typedef enum logic [1:0] {StIdle, StRun, StLoad} state_e;

    localparam logic [DIV_W-1:0] CntOne = 1;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;  // 1 = counting up
    logic [2:0]       switch_q, switch_d;
    logic [2:0]       enable_q, enable_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             ready_q, ready_d;

    logic             load_acc;
    logic [2:0]       step_sw;
    logic             step_dir;
    logic             step_wrap;

    assign load_acc = load_valid && ready_q;

    // Index, direction and boundary flag that a step would produce in the current mode.
    always_comb begin
        step_sw   = switch_q;
        step_dir  = dir_q;
        step_wrap = 1'b0;
        unique case (mode)
            2'b01: begin
                step_sw   = switch_q + 3'd1;
                step_wrap = (switch_q == 3'd7);
            end
            2'b10: begin
                step_sw   = switch_q - 3'd1;
                step_wrap = (switch_q == 3'd0);
            end
            2'b11: begin
                // Endpoints always turn inward; only an in-phase arrival is a reversal.
                if (switch_q == 3'd7) begin
                    step_sw = 3'd6;
                    if (dir_q) begin
                        step_dir  = 1'b0;
                        step_wrap = 1'b1;
                    end
                end else if (switch_q == 3'd0) begin
                    step_sw = 3'd1;
                    if (!dir_q) begin
                        step_dir  = 1'b1;
                        step_wrap = 1'b1;
                    end
                end else begin
                    step_sw = dir_q ? switch_q + 3'd1 : switch_q - 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        switch_d = switch_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        ready_d  = 1'b1;
        enable_d = blank ? 3'b000 : 3'b100;

        if (load_acc) begin
            // A load wins over any step decided in the same cycle.
            state_d  = StLoad;
            switch_d = load_idx;
            cnt_d    = '0;
            ready_d  = 1'b0;
            if (load_idx == 3'd7) begin
                dir_d = 1'b0;
            end else if (load_idx == 3'd0) begin
                dir_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d   = '0;
                    state_d = run ? StRun : StIdle;
                end
                StRun: begin
                    if (!run) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (mode != 2'b00) begin
                        // >= so that lowering period below the running count still steps.
                        if (cnt_q >= period) begin
                            cnt_d    = '0;
                            switch_d = step_sw;
                            dir_d    = step_dir;
                            tick_d   = 1'b1;
                            wrap_d   = step_wrap;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                end
                StLoad: begin
                    cnt_d   = '0;
                    state_d = run ? StRun : StIdle;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dir_q    <= 1'b1;
            switch_q <= 3'd0;
            enable_q <= 3'b000;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            switch_q <= switch_d;
            enable_q <= enable_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
            ready_q  <= ready_d;
        end
    end

    assign load_ready = ready_q;
    assign switch     = switch_q;
    assign enable     = enable_q;
    assign tick       = tick_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Bench for led_scan_sequencer: a table of reset/blank/scan vectors, hand sequences for the
// multi-cycle corners, then random stimulus against a cycle-level reference model.
module tb_led_scan_sequencer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [1:0]    mode;
    logic [DW-1:0] period;
    logic          blank;
    logic          load_valid;
    logic [2:0]    load_idx;
    logic          load_ready;
    logic [2:0]    switch;
    logic [2:0]    enable;
    logic          tick;
    logic          wrap;

    always #5 clk = ~clk;

    led_scan_sequencer #(.DIV_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mode      (mode),
        .period    (period),
        .blank     (blank),
        .load_valid(load_valid),
        .load_idx  (load_idx),
        .load_ready(load_ready),
        .switch    (switch),
        .enable    (enable),
        .tick      (tick),
        .wrap      (wrap)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: index, prescaler count, direction, and whether the last cycle was running.
    int m_sw, m_cnt, m_en;
    bit m_up, m_ready, m_active, m_tick, m_wrap;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        m_wrap = 0;
        case (mode)
            2'b01: begin m_wrap = (m_sw == 7); m_sw = (m_sw + 1) % 8; end
            2'b10: begin m_wrap = (m_sw == 0); m_sw = (m_sw + 7) % 8; end
            2'b11: begin
                if (m_sw == 7) begin
                    m_wrap = m_up; m_up = 0; m_sw = 6;
                end else if (m_sw == 0) begin
                    m_wrap = !m_up; m_up = 1; m_sw = 1;
                end else begin
                    m_sw = m_up ? m_sw + 1 : m_sw - 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_sw = 0; m_cnt = 0; m_en = 0; m_up = 1;
            m_ready = 0; m_active = 0; m_tick = 0; m_wrap = 0;
            return;
        end
        m_en   = blank ? 0 : 4;
        m_tick = 0;
        m_wrap = 0;
        if (load_valid && m_ready) begin
            m_sw = int'(load_idx); m_cnt = 0; m_ready = 0; m_active = 0;
            if (load_idx == 3'd7) m_up = 0;
            if (load_idx == 3'd0) m_up = 1;
            return;
        end
        if (m_active && run && mode != 2'b00) begin
            if (m_cnt >= int'(period)) begin
                m_cnt = 0; m_tick = 1; model_step();
            end else begin
                m_cnt++;
            end
        end else if (!(m_active && run)) begin
            m_cnt = 0;
        end
        m_active = run;
        m_ready  = 1;
    endtask

    // One clock: advance the model on the edge, then compare every output 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("model_switch", int'(switch), m_sw);
        check("model_enable", int'(enable), m_en);
        check("model_tick", int'(tick), int'(m_tick));
        check("model_wrap", int'(wrap), int'(m_wrap));
        check("model_ready", int'(load_ready), int'(m_ready));
    endtask

    typedef struct {
        logic       r;
        logic       rn;
        logic [1:0] md;
        int         per;
        logic       bl;
        logic       lv;
        logic [2:0] li;
        int         sw;
        int         en;
        int         tk;
        int         wr;
        int         rdy;
    } vec_t;

    vec_t vecs[12];
    int   pp_exp[15];

    initial begin
        // rst run mode per blank lv idx | switch enable tick wrap ready
        vecs[0]  = '{1'b0, 1'b1, 2'b01, 0, 1'b0, 1'b1, 3'd3, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 2'b11, 0, 1'b0, 1'b1, 3'd5, 0, 0, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 2'b10, 3, 1'b1, 1'b0, 3'd7, 0, 0, 0, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 2, 1'b0, 1'b0, 3'd0, 0, 4, 0, 0, 1};
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 2, 1'b1, 1'b0, 3'd0, 0, 0, 0, 0, 1};
        vecs[5]  = '{1'b1, 1'b1, 2'b01, 2, 1'b0, 1'b0, 3'd0, 0, 4, 0, 0, 1};
        vecs[6]  = '{1'b1, 1'b1, 2'b01, 2, 1'b0, 1'b0, 3'd0, 0, 4, 0, 0, 1};
        vecs[7]  = '{1'b1, 1'b1, 2'b01, 2, 1'b0, 1'b0, 3'd0, 0, 4, 0, 0, 1};
        vecs[8]  = '{1'b1, 1'b1, 2'b01, 2, 1'b0, 1'b0, 3'd0, 1, 4, 1, 0, 1};
        vecs[9]  = '{1'b1, 1'b1, 2'b01, 2, 1'b0, 1'b0, 3'd0, 1, 4, 0, 0, 1};
        vecs[10] = '{1'b1, 1'b1, 2'b01, 2, 1'b0, 1'b0, 3'd0, 1, 4, 0, 0, 1};
        vecs[11] = '{1'b1, 1'b1, 2'b01, 2, 1'b0, 1'b0, 3'd0, 2, 4, 1, 0, 1};
        pp_exp = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

        rst = 1'b0; run = 1'b0; mode = 2'b00; period = '0;
        blank = 1'b0; load_valid = 1'b0; load_idx = 3'd0;

        foreach (vecs[i]) begin
            rst = vecs[i].r; run = vecs[i].rn; mode = vecs[i].md;
            period = DW'(vecs[i].per); blank = vecs[i].bl;
            load_valid = vecs[i].lv; load_idx = vecs[i].li;
            cycle();
            check($sformatf("vec%0d_switch", i), int'(switch), vecs[i].sw);
            check($sformatf("vec%0d_enable", i), int'(enable), vecs[i].en);
            check($sformatf("vec%0d_tick", i), int'(tick), vecs[i].tk);
            check($sformatf("vec%0d_wrap", i), int'(wrap), vecs[i].wr);
            check($sformatf("vec%0d_ready", i), int'(load_ready), vecs[i].rdy);
        end

        // Up scan continues from 2 with a step every 3 cycles; wrap only on 7->0.
        for (int k = 3; k <= 8; k++) begin
            cycle(); cycle(); cycle();
            check("up_tick", int'(tick), 1);
            check("up_switch", int'(switch), k % 8);
            check("up_wrap", int'(wrap), (k % 8 == 0) ? 1 : 0);
        end

        // Ping-pong at full rate.
        mode = 2'b11; period = '0;
        foreach (pp_exp[i]) begin
            cycle();
            check("pp_switch", int'(switch), pp_exp[i]);
            check("pp_wrap", int'(wrap), (i == 7 || i == 14) ? 1 : 0);
        end

        // Load coincident with a step.
        mode = 2'b01; load_valid = 1'b1; load_idx = 3'd5;
        cycle();
        check("load_switch", int'(switch), 5);
        check("load_tick", int'(tick), 0);
        check("load_ready_low", int'(load_ready), 0);
        load_valid = 1'b0;
        cycle();
        check("load_hold", int'(switch), 5);
        check("load_ready_back", int'(load_ready), 1);
        cycle();
        check("load_next", int'(switch), 6);

        // Down scan: shrink period below the running count, step 0 -> 7 with wrap.
        mode = 2'b10; period = DW'(10); load_valid = 1'b1; load_idx = 3'd0;
        cycle();
        check("down_load", int'(switch), 0);
        load_valid = 1'b0;
        cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("down_wait_tick", int'(tick), 0);
        end
        period = DW'(3);
        cycle();
        check("shrink_tick", int'(tick), 1);
        check("shrink_switch", int'(switch), 7);
        check("shrink_wrap", int'(wrap), 1);

        // run drop mid-count freezes the index; restart waits period+1 cycles.
        mode = 2'b01; period = DW'(4);
        cycle(); cycle();
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("frozen_switch", int'(switch), 7);
            check("frozen_tick", int'(tick), 0);
        end
        run = 1'b1;
        cycle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("restart_wait", int'(tick), 0);
        end
        cycle();
        check("restart_tick", int'(tick), 1);
        check("restart_switch", int'(switch), 0);
        check("restart_wrap", int'(wrap), 1);

        // Reset mid ping-pong while heading down: index and direction return to 0/up.
        mode = 2'b11; period = '0; load_valid = 1'b1; load_idx = 3'd7;
        cycle();
        load_valid = 1'b0;
        cycle(); cycle(); cycle();
        check("pp_down", int'(switch), 5);
        rst = 1'b0;
        cycle();
        check("rst_switch", int'(switch), 0);
        check("rst_enable", int'(enable), 0);
        check("rst_ready", int'(load_ready), 0);
        rst = 1'b1;
        cycle();
        check("rel_ready", int'(load_ready), 1);
        check("rel_enable", int'(enable), 4);
        cycle();
        check("rel_step1", int'(switch), 1);
        check("rel_wrap", int'(wrap), 0);
        cycle();
        check("rel_step2", int'(switch), 2);

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 99) >= 2);
            run        = ($urandom_range(0, 9) != 0);
            mode       = 2'($urandom_range(0, 3));
            period     = DW'($urandom_range(0, 4));
            blank      = ($urandom_range(0, 7) == 0);
            load_valid = ($urandom_range(0, 9) == 0);
            load_idx   = 3'($urandom_range(0, 7));
            cycle();
            if (!(tick || !wrap)) check("wrap_implies_tick", int'(tick), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_scan_sequencer.md
Name: led_scan_sequencer

Overview:
- Upstream driver for the registered 3-to-8 active-low LED decoder stage.
- Generates the decoder's 3-bit index (switch) and 3-bit enable code.
- Auto-steps the index through programmable up, down or ping-pong scans at a runtime-set rate.
- Accepts direct index loads through a valid/ready handshake, so LED patterns come from one control point instead of raw switches.

Parameters:
- DIV_W, 8, width of prescaler counter and period input.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- run  in  1  1 = scanning allowed; 0 = hold index, prescaler cleared
- mode  in  2  00 hold, 01 up, 10 down, 11 ping-pong
- period  in  DIV_W  step interval; one step every period+1 cycles
- blank  in  1  1 = force enable code to 3'b000 (all LEDs off downstream)
- load_valid  in  1  request to load load_idx
- load_idx  in  3  index to load
- load_ready  out  1  load accepted when load_valid && load_ready
- switch  out  3  current index to decoder
- enable  out  3  3'b100 = decoder active, 3'b000 = blanked
- tick  out  1  one-cycle pulse on every index step
- wrap  out  1  one-cycle pulse on scan boundary

Behaviour:
- All outputs are registered. Reset is sampled at posedge clk with rst==0.
- Reset values: switch=0, enable=3'b000, tick=0, wrap=0, load_ready=0, prescaler cnt=0, direction dir=up, state=IDLE.
- rst low for any cycle mid-operation restores the reset values; no partial step completes.
- States:
  - IDLE: run==0.
  - RUN: run==1.
  - LOAD: exactly one cycle after a load is accepted.
- Transitions:
  - IDLE->RUN when run==1.
  - RUN->IDLE when run==0.
  - IDLE/RUN->LOAD on accepted load.
  - LOAD->RUN if run==1, else IDLE.
- load_ready=1 in IDLE and RUN, 0 in LOAD and during reset. It first rises the cycle after rst is released.
- enable: 3'b100 when out of reset and blank==0, else 3'b000. It follows blank with one cycle of latency and is independent of run/mode.
- Prescaler in RUN with mode!=00:
  - Step condition is cnt>=period (>= so that lowering period mid-count cannot stall).
  - On a step: cnt<=0, switch updates, tick=1. Otherwise cnt<=cnt+1.
  - period=0 gives a step every cycle.
- Prescaler elsewhere:
  - In IDLE or LOAD: cnt<=0.
  - mode==00 in RUN: cnt held, no steps.
- Step rules (arithmetic mod 8):
  - 01: switch+1. wrap=1 on the 7->0 step.
  - 10: switch-1. wrap=1 on the 0->7 step.
  - 11: at 7 with dir=up, go to 6 and set dir=down. At 0 with dir=down, go to 1 and set dir=up. wrap=1 on each reversal step. Otherwise move by dir.
  - In 11 only, an out-of-phase endpoint is corrected: at 7 stepping with dir=down -> 6; at 0 with dir=up -> 1; dir unchanged and wrap=0.
- mode or period changes take effect at the next step decision. cnt is not cleared by a mode change.
- First step after entering RUN (from IDLE or LOAD) occurs period+1 cycles later.
- Load:
  - Accepted load sets switch<=load_idx on the next edge, cnt<=0, tick=0, wrap=0.
  - A load takes priority over a coincident step.
  - dir after load: load_idx==7 -> down; load_idx==0 -> up; otherwise unchanged.
  - load_valid while load_ready==0 is ignored. No queuing; the requester must hold valid.
- Simultaneous run falling and load accepted: the load is applied, LOAD is entered, then IDLE.
- tick and wrap are never high outside the cycle after a step. wrap implies tick.

Test Plan:
- Reset and blank: hold rst=0 for 3 cycles with any inputs -> switch=0, enable=000, load_ready=0. Release with blank=0 -> enable=100 and load_ready=1 one cycle later. Assert blank -> enable=000 the next cycle.
- Up scan: mode=01, period=2, run=1 from switch=0 -> tick every 3 cycles, sequence 1..7,0. wrap coincides only with the 7->0 tick.
- Ping-pong: mode=11, period=0 -> switch 0,1,...,7,6,...,0,1. wrap pulses on the 7->6 and 0->1 steps only.
- Load vs step: mode=01, period=0, load_valid with load_idx=5 in a step cycle -> switch=5, tick=0, load_ready=0 for one cycle. The next step gives 6 after one further cycle.
- Down wrap and period shrink: mode=10, period=10. When cnt reaches 6, change period to 3 -> step on the next cycle. From switch=0 -> 7 with wrap=1.
- run drop and mid-scan reset: run=0 mid-count -> switch frozen. run=1 -> next step exactly period+1 cycles later. Pulse rst=0 mid-scan -> switch=0, dir=up.
